clk_div_bank: RTL and testbench



---
 rtl/clk_div_bank_if.sv | 16 +
 rtl/clk_div_bank.sv | 125 ++++++++++++
 tb/tb_clk_div_bank.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// Control and status bundle for the clock-divider bank: per-channel run/ratio
// requests in, divided clocks, rising-edge ticks and busy flags out.
interface clk_div_bank_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]            en;
  logic [NUM_CH-1:0][CNT_W-1:0] half_p;
  logic                         sync;
  logic [NUM_CH-1:0]            clk_out;
  logic [NUM_CH-1:0]            tick;
  logic [NUM_CH-1:0]            busy;

  modport master (output en, half_p, sync, input clk_out, tick, busy);
  modport slave  (input en, half_p, sync, output clk_out, tick, busy);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable 50%-duty clock dividers with
// glitch-free start/stop, phase-boundary ratio updates and a shared phase sync.
module clk_div_ch #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] half_p_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             term;

  assign term = (cnt_q == shadow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= CNT_W'(DEFAULT_HALF);
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en_i) begin
          state_d  = RUN;
          shadow_d = half_p_i;
        end
      end
      default: begin
        if (sync_i) begin
          cnt_d    = '0;
          clk_d    = 1'b0;
          shadow_d = half_p_i;
          state_d  = en_i ? RUN : IDLE;
        end else begin
          if (term) begin
            cnt_d    = '0;
            clk_d    = ~clk_q;
            tick_d   = ~clk_q;
            shadow_d = half_p_i;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Stop only from the low phase: a high phase always runs to its full length.
          if (state_q == RUN && !en_i) begin
            if (!clk_q || term) begin
              state_d = IDLE;
              cnt_d   = '0;
              clk_d   = 1'b0;
              tick_d  = 1'b0;
            end else begin
              state_d = STOPPING;
            end
          end else if (state_q == STOPPING) begin
            if (en_i) begin
              state_d = RUN;
            end else if (term) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
      end
    endcase
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign busy_o    = (state_q != IDLE);
endmodule

module clk_div_bank #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 1
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_bank_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (bus.en[i]),
      .half_p_i (bus.half_p[i]),
      .sync_i   (bus.sync),
      .clk_out_o(bus.clk_out[i]),
      .tick_o   (bus.tick[i]),
      .busy_o   (bus.busy[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed vector bench for clk_div_bank: per-cycle expected clk_out/tick/busy
// for two channels, plus an asynchronous mid-phase reset sequence.
module tb_clk_div_bank;
  localparam int NCH = 2;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
  clk_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [1:0]    en;
    logic [CW-1:0] h0;
    logic [CW-1:0] h1;
    logic          sync;
    logic [1:0]    clk_o;
    logic [1:0]    tick;
    logic [1:0]    busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t r(logic [1:0] en, int h0, int h1, logic s,
                             logic [1:0] c, logic [1:0] t, logic [1:0] b);
    vec_t v;
    v.en = en; v.h0 = CW'(h0); v.h1 = CW'(h1); v.sync = s;
    v.clk_o = c; v.tick = t; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input int h0, input int h1, input logic s);
    bus.en        = en;
    bus.half_p[0] = CW'(h0);
    bus.half_p[1] = CW'(h1);
    bus.sync      = s;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] c, input logic [1:0] t,
                         input logic [1:0] b);
    chk({tag, " clk_out"}, bus.clk_out, c);
    chk({tag, " tick"},    bus.tick,    t);
    chk({tag, " busy"},    bus.busy,    b);
  endtask

  initial begin
    // ch0: start at div-4, speed up to div-2, change to half 3 mid-phase, then stop while high
    tbl.push_back(r(2'b01,1,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b01,2'b01,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b01,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b01,2'b01,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b01,2'b00,2'b01));
    tbl.push_back(r(2'b01,1,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b01,2'b01,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b01,2'b01,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,0,0,0, 2'b01,2'b01,2'b01));
    for (int i = 0; i < 4; i++) tbl.push_back(r(2'b01,3,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,3,0,0, 2'b01,2'b01,2'b01));
    for (int i = 0; i < 3; i++) tbl.push_back(r(2'b01,3,0,0, 2'b01,2'b00,2'b01));
    for (int i = 0; i < 4; i++) tbl.push_back(r(2'b01,3,0,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b01,3,0,0, 2'b01,2'b01,2'b01));
    for (int i = 0; i < 3; i++) tbl.push_back(r(2'b00,3,0,0, 2'b01,2'b00,2'b01));
    for (int i = 0; i < 3; i++) tbl.push_back(r(2'b00,3,0,0, 2'b00,2'b00,2'b00));
    // both channels at half 2, ch1 one cycle late, then sync realigns them
    tbl.push_back(r(2'b01,2,2,0, 2'b00,2'b00,2'b01));
    tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b01,2'b01,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b10,2'b11));
    tbl.push_back(r(2'b11,2,2,1, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b11,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b00,2'b11));
    for (int i = 0; i < 3; i++) tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b11,2'b11));
    // ch1 dropped and re-requested inside its high phase: period stays 6
    tbl.push_back(r(2'b01,2,2,0, 2'b11,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b00,2'b11));
    for (int i = 0; i < 3; i++) tbl.push_back(r(2'b11,2,2,0, 2'b00,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b11,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b00,2'b11));
    tbl.push_back(r(2'b11,2,2,0, 2'b11,2'b00,2'b11));
    // ch0 en dropped on its terminal count while high: falls and goes straight to IDLE
    tbl.push_back(r(2'b10,2,2,0, 2'b00,2'b00,2'b10));

    drive(2'b00, 0, 0, 1'b0);
    #12;
    chk_all("reset", 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, int'(tbl[i].h0), int'(tbl[i].h1), tbl[i].sync);
      step();
      chk_all($sformatf("row%0d", i), tbl[i].clk_o, tbl[i].tick, tbl[i].busy);
    end

    // ch0 restarted at half 1 (ch1 stops from low phase), then async reset while high
    drive(2'b01, 1, 2, 1'b0);
    step(); chk_all("ar0", 2'b00, 2'b00, 2'b01);
    step(); chk_all("ar1", 2'b00, 2'b00, 2'b01);
    step(); chk_all("ar2", 2'b01, 2'b01, 2'b01);
    #3;
    rst = 1'b1;
    #1;
    chk_all("ar_async", 2'b00, 2'b00, 2'b00);
    step(); chk_all("ar_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    step(); chk_all("rel0", 2'b00, 2'b00, 2'b01);
    step(); chk_all("rel1", 2'b00, 2'b00, 2'b01);
    step(); chk_all("rel2", 2'b01, 2'b01, 2'b01);
    step(); chk_all("rel3", 2'b01, 2'b00, 2'b01);
    step(); chk_all("rel4", 2'b00, 2'b00, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
